// File: rtl/exec_sched_pkg.sv
// Shared encodings for the execution scheduler: func codes, FU state and CDB source.
// Used by exec_sched and fu_tracker (EXEC_SCHED_FLUSH_EN adds the flush input there).
package exec_sched_pkg;

  localparam int ROB_W  = 3;
  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
  localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
  localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_BUSY = 2'd1,
    FU_DONE = 2'd2
  } fu_state_e;

  typedef enum logic {
    CDB_SRC_ADD = 1'b0,
    CDB_SRC_MUL = 1'b1
  } cdb_src_e;

  function automatic logic is_addsub(input logic [FUNC_W-1:0] f);
    return (f == FUNC_ADD) || (f == FUNC_SUB);
  endfunction

  function automatic logic is_muldiv(input logic [FUNC_W-1:0] f);
    return (f == FUNC_MUL) || (f == FUNC_DIV);
  endfunction

endpackage

// File: rtl/fu_tracker.sv
// One functional unit's IDLE/BUSY/DONE machine with latency countdown and ROB latch.
// With EXEC_SCHED_FLUSH_EN defined, a flush input returns the unit to IDLE.
module fu_tracker
  import exec_sched_pkg::*;
#(
  parameter int LAT_MAX = 2
) (
  input  logic                          clk1,
  input  logic                          rst,
`ifdef EXEC_SCHED_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic                          start,
  input  logic [$clog2(LAT_MAX+1)-1:0]  lat,
  input  logic [ROB_W-1:0]              rob_in,
  input  logic                          cdb_win,
  output fu_state_e                     state,
  output logic [ROB_W-1:0]              rob
);

  localparam int CW = $clog2(LAT_MAX + 1);

  fu_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ROB_W-1:0] rob_q, rob_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rob_d   = rob_q;
    unique case (state_q)
      FU_IDLE: begin
        if (start) begin
          rob_d   = rob_in;
          // Countdown holds the cycles still to spend in BUSY after this edge.
          cnt_d   = lat - CW'(1);
          state_d = (lat == CW'(1)) ? FU_DONE : FU_BUSY;
        end
      end
      FU_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = FU_DONE;
      end
      FU_DONE: begin
        if (cdb_win) state_d = FU_IDLE;
      end
      default: state_d = FU_IDLE;
    endcase
`ifdef EXEC_SCHED_FLUSH_EN
    if (flush) begin
      state_d = FU_IDLE;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= FU_IDLE;
      cnt_q   <= '0;
      rob_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rob_q   <= rob_d;
    end
  end

  assign state = state_q;
  assign rob   = rob_q;

endmodule

// File: rtl/exec_sched.sv
// Issue scheduler for an add/sub and a mul/div unit with round-robin grant and CDB arbitration.
// Defining EXEC_SCHED_FLUSH_EN adds a flush input that idles both units and suppresses grant/CDB.
module exec_sched
  import exec_sched_pkg::*;
#(
  parameter int N_RS    = 4,
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 6
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic [N_RS-1:0]     req,
  input  logic [4*N_RS-1:0]   req_func,
  input  logic [3*N_RS-1:0]   req_rob,
  output logic [N_RS-1:0]     grant,
  output logic                add_start,
  output logic [3:0]          add_func,
  output logic                mul_start,
  output logic [3:0]          mul_func,
  output logic                add_busy,
  output logic                mul_busy,
  output logic                cdb_valid,
  output logic [2:0]          cdb_rob,
  output logic                cdb_src
`ifdef EXEC_SCHED_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  localparam int PW      = (N_RS > 1) ? $clog2(N_RS) : 1;
  localparam int MUL_MAX = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int ADD_CW  = $clog2(LAT_ADD + 1);
  localparam int MUL_CW  = $clog2(MUL_MAX + 1);

  // Returns {found, index} of the first set bit of elig at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [N_RS-1:0] elig, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    logic [PW:0] idx;
    res = '0;
    for (int k = N_RS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_RS)) idx = idx - (PW+1)'(N_RS);
      if (elig[idx[PW-1:0]]) res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(N_RS - 1)) ? '0 : idx + PW'(1);
  endfunction

  logic [FUNC_W-1:0] func_arr [N_RS];
  logic [ROB_W-1:0]  rob_arr  [N_RS];
  logic [N_RS-1:0]   elig_add, elig_mul;

  generate
    for (genvar gi = 0; gi < N_RS; gi++) begin : g_rs
      assign func_arr[gi] = req_func[4*gi +: 4];
      assign rob_arr[gi]  = req_rob[3*gi +: 3];
      assign elig_add[gi] = req[gi] && is_addsub(func_arr[gi]);
      assign elig_mul[gi] = req[gi] && is_muldiv(func_arr[gi]);
    end
  endgenerate

  logic [PW-1:0]    add_ptr_q, add_ptr_d, mul_ptr_q, mul_ptr_d;
  logic             tie_q, tie_d;
  logic [PW:0]      add_pick, mul_pick;
  logic             hold;
  logic             add_done, mul_done, add_win, mul_win;
  logic [ROB_W-1:0] add_rob_in, mul_rob_in;
  logic [MUL_CW-1:0] mul_lat;
  fu_state_e        add_state, mul_state;
  logic [ROB_W-1:0] add_rob, mul_rob;

`ifdef EXEC_SCHED_FLUSH_EN
  assign hold = rst | flush;
`else
  assign hold = rst;
`endif

  always_comb begin
    add_pick   = rr_pick(elig_add, add_ptr_q);
    mul_pick   = rr_pick(elig_mul, mul_ptr_q);
    add_start  = !hold && (add_state == FU_IDLE) && add_pick[PW];
    mul_start  = !hold && (mul_state == FU_IDLE) && mul_pick[PW];
    grant      = '0;
    add_func   = '0;
    mul_func   = '0;
    add_rob_in = '0;
    mul_rob_in = '0;
    add_ptr_d  = add_ptr_q;
    mul_ptr_d  = mul_ptr_q;
    if (add_start) begin
      grant[add_pick[PW-1:0]] = 1'b1;
      add_func   = func_arr[add_pick[PW-1:0]];
      add_rob_in = rob_arr[add_pick[PW-1:0]];
      add_ptr_d  = next_ptr(add_pick[PW-1:0]);
    end
    if (mul_start) begin
      grant[mul_pick[PW-1:0]] = 1'b1;
      mul_func   = func_arr[mul_pick[PW-1:0]];
      mul_rob_in = rob_arr[mul_pick[PW-1:0]];
      mul_ptr_d  = next_ptr(mul_pick[PW-1:0]);
    end
    mul_lat = (mul_func == FUNC_DIV) ? MUL_CW'(LAT_DIV) : MUL_CW'(LAT_MUL);

    // tie_q high means mul/div takes the next tie; it flips every time a tie is resolved.
    add_done  = (add_state == FU_DONE);
    mul_done  = (mul_state == FU_DONE);
    mul_win   = !hold && mul_done && (!add_done || tie_q);
    add_win   = !hold && add_done && !(mul_done && tie_q);
    tie_d     = tie_q;
    if (!hold && add_done && mul_done) tie_d = !tie_q;
    cdb_valid = add_win | mul_win;
    cdb_src   = mul_win ? CDB_SRC_MUL : CDB_SRC_ADD;
    cdb_rob   = mul_win ? mul_rob : (add_win ? add_rob : '0);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      add_ptr_q <= '0;
      mul_ptr_q <= '0;
      tie_q     <= 1'b1;
    end else begin
      add_ptr_q <= add_ptr_d;
      mul_ptr_q <= mul_ptr_d;
      tie_q     <= tie_d;
    end
  end

  fu_tracker #(.LAT_MAX(LAT_ADD)) u_add (
    .clk1    (clk1),
    .rst     (rst),
`ifdef EXEC_SCHED_FLUSH_EN
    .flush   (flush),
`endif
    .start   (add_start),
    .lat     (ADD_CW'(LAT_ADD)),
    .rob_in  (add_rob_in),
    .cdb_win (add_win),
    .state   (add_state),
    .rob     (add_rob)
  );

  fu_tracker #(.LAT_MAX(MUL_MAX)) u_mul (
    .clk1    (clk1),
    .rst     (rst),
`ifdef EXEC_SCHED_FLUSH_EN
    .flush   (flush),
`endif
    .start   (mul_start),
    .lat     (mul_lat),
    .rob_in  (mul_rob_in),
    .cdb_win (mul_win),
    .state   (mul_state),
    .rob     (mul_rob)
  );

  assign add_busy = (add_state != FU_IDLE);
  assign mul_busy = (mul_state != FU_IDLE);

endmodule

// File: tb/tb_exec_sched.sv
// Self-checking bench for exec_sched: directed scenarios plus random traffic against a timestamp model.
// Define EXEC_SCHED_FLUSH_EN to also exercise the flush input.
module tb_exec_sched;

  localparam int N  = 4;
  localparam int LA = 2;
  localparam int LM = 4;
  localparam int LD = 6;
`ifdef EXEC_SCHED_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic           clk1 = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] req_func = '0;
  logic [3*N-1:0] req_rob = '0;
  logic [N-1:0]   grant;
  logic           add_start, mul_start, add_busy, mul_busy, cdb_valid, cdb_src;
  logic [3:0]     add_func, mul_func;
  logic [2:0]     cdb_rob;

  exec_sched #(.N_RS(N), .LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .req       (req),
    .req_func  (req_func),
    .req_rob   (req_rob),
    .grant     (grant),
    .add_start (add_start),
    .add_func  (add_func),
    .mul_start (mul_start),
    .mul_func  (mul_func),
    .add_busy  (add_busy),
    .mul_busy  (mul_busy),
    .cdb_valid (cdb_valid),
    .cdb_rob   (cdb_rob),
    .cdb_src   (cdb_src)
`ifdef EXEC_SCHED_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk1 = ~clk1;

  int compared = 0;
  int mismatched = 0;

  // Reference model: each unit is free or holds one op with the cycle its result becomes available.
  int         cyc = 0;
  bit         m_known = 0;
  bit         m_use [2];
  int         m_done_at [2];
  logic [2:0] m_rob [2];
  int         m_ptr [2];
  bit         m_tie = 1;
  int         m_win;
  bit         m_tie_case;
  logic [N-1:0] e_grant;
  int         e_idx [2];
  logic [3:0] e_func [2];
  bit         e_cdb;
  logic [2:0] e_rob;
  bit         e_src;

  logic [N-1:0] s_grant;
  logic s_add_start, s_mul_start, s_add_busy, s_mul_busy, s_cdb_valid, s_cdb_src;
  logic [3:0] s_add_func, s_mul_func;
  logic [2:0] s_cdb_rob;

  function automatic int unit_of(input logic [3:0] f);
    if (f == 4'd0 || f == 4'd1) return 0;
    if (f == 4'd2 || f == 4'd3) return 1;
    return -1;
  endfunction

  function automatic int lat_of(input logic [3:0] f);
    if (f == 4'd2) return LM;
    if (f == 4'd3) return LD;
    return LA;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_eval();
    bit rdy [2];
    e_grant = '0;
    e_cdb = 0;
    e_rob = '0;
    e_src = 0;
    m_win = -1;
    m_tie_case = 0;
    for (int u = 0; u < 2; u++) begin
      e_idx[u] = -1;
      e_func[u] = '0;
      rdy[u] = 0;
    end
    if (!rst && !flush) begin
      for (int u = 0; u < 2; u++) begin
        if (!m_use[u]) begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr[u] + k) % N;
            if (e_idx[u] < 0 && req[i] && unit_of(req_func[4*i +: 4]) == u) begin
              e_idx[u] = i;
              e_grant[i] = 1'b1;
              e_func[u] = req_func[4*i +: 4];
            end
          end
        end
        rdy[u] = m_use[u] && (cyc >= m_done_at[u]);
      end
      m_tie_case = rdy[0] && rdy[1];
      if (m_tie_case) m_win = m_tie ? 1 : 0;
      else if (rdy[1]) m_win = 1;
      else if (rdy[0]) m_win = 0;
      if (m_win >= 0) begin
        e_cdb = 1;
        e_rob = m_rob[m_win];
        e_src = (m_win == 1);
      end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_use = '{0, 0};
      m_ptr = '{0, 0};
      m_tie = 1;
      m_known = 1;
    end else if (flush) begin
      m_use = '{0, 0};
    end else begin
      if (m_win >= 0) begin
        m_use[m_win] = 0;
        if (m_tie_case) m_tie = (m_win == 0);
      end
      for (int u = 0; u < 2; u++) begin
        if (e_idx[u] >= 0) begin
          m_use[u] = 1;
          m_rob[u] = req_rob[3*e_idx[u] +: 3];
          m_done_at[u] = cyc + lat_of(e_func[u]);
          m_ptr[u] = (e_idx[u] + 1) % N;
        end
      end
    end
    cyc++;
  endtask

  task automatic run_cycle();
    @(negedge clk1);
    model_eval();
    s_grant = grant;       s_add_start = add_start; s_mul_start = mul_start;
    s_add_func = add_func; s_mul_func = mul_func;   s_add_busy = add_busy;
    s_mul_busy = mul_busy; s_cdb_valid = cdb_valid; s_cdb_rob = cdb_rob;
    s_cdb_src = cdb_src;
    if (m_known) begin
      check("grant", 32'(s_grant), 32'(e_grant));
      check("add_start", 32'(s_add_start), 32'(e_idx[0] >= 0));
      check("add_func", 32'(s_add_func), 32'(e_func[0]));
      check("mul_start", 32'(s_mul_start), 32'(e_idx[1] >= 0));
      check("mul_func", 32'(s_mul_func), 32'(e_func[1]));
      check("add_busy", 32'(s_add_busy), 32'(m_use[0]));
      check("mul_busy", 32'(s_mul_busy), 32'(m_use[1]));
      check("cdb_valid", 32'(s_cdb_valid), 32'(e_cdb));
      check("cdb_rob", 32'(s_cdb_rob), 32'(e_rob));
      check("cdb_src", 32'(s_cdb_src), 32'(e_src));
      if (e_grant != '0) $display("issue cyc=%0d grant=%b", cyc, e_grant);
      if (e_cdb) $display("cdb   cyc=%0d rob=%0d src=%0d", cyc, e_rob, e_src);
    end
    @(posedge clk1);
    #1;
    model_commit();
  endtask

  task automatic set_req(input int i, input logic [3:0] f, input logic [2:0] r);
    req[i] = 1'b1;
    req_func[4*i +: 4] = f;
    req_rob[3*i +: 3] = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    req = '0;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Reset state
    do_reset();
    run_cycle();
    check("rst_grant", 32'(s_grant), 32'd0);
    check("rst_busy", 32'({s_add_busy, s_mul_busy}), 32'd0);
    check("rst_cdb", 32'(s_cdb_valid), 32'd0);

    // Single add, result two cycles after grant
    set_req(0, 4'b0000, 3'd3);
    run_cycle();
    check("add_grant", 32'(s_grant), 32'b0001);
    check("add_start_t", 32'(s_add_start), 32'd1);
    req = '0;
    run_cycle();
    run_cycle();
    check("add_cdb_v", 32'(s_cdb_valid), 32'd1);
    check("add_cdb_rob", 32'(s_cdb_rob), 32'd3);
    check("add_cdb_src", 32'(s_cdb_src), 32'd0);

    // Four add requesters held: round-robin, reissue after each broadcast
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 4'b0000, 3'(i));
    for (int c = 0; c < 8; c++) begin
      run_cycle();
      if (c == 0) check("rr_g0", 32'(s_grant), 32'b0001);
      if (c == 3) check("rr_g1", 32'(s_grant), 32'b0010);
      if (c == 6) check("rr_g2", 32'(s_grant), 32'b0100);
      if (c == 1 || c == 4) check("rr_idle", 32'(s_grant), 32'd0);
      if (c == 2 || c == 5) check("rr_cdb", 32'(s_cdb_valid), 32'd1);
    end
    req = '0;

    // Mul/add tie: mul wins first after reset, add one cycle later
    do_reset();
    set_req(0, 4'b0010, 3'd5);
    run_cycle();
    check("tie_mul_start", 32'(s_mul_start), 32'd1);
    req = '0;
    run_cycle();
    set_req(1, 4'b0000, 3'd1);
    run_cycle();
    check("tie_add_grant", 32'(s_grant), 32'b0010);
    req = '0;
    run_cycle();
    run_cycle();
    check("tie_t4", 32'({s_cdb_valid, s_cdb_src, s_cdb_rob}), 32'b1_1_101);
    run_cycle();
    check("tie_t5", 32'({s_cdb_valid, s_cdb_src, s_cdb_rob}), 32'b1_0_001);

    // Unsupported func is never granted
    do_reset();
    set_req(0, 4'b0100, 3'd2);
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      check("bad_grant", 32'(s_grant), 32'd0);
      check("bad_busy", 32'({s_add_busy, s_mul_busy}), 32'd0);
    end
    req = '0;

    // Reset during a div discards the result
    do_reset();
    set_req(0, 4'b0011, 3'd6);
    run_cycle();
    check("div_start", 32'(s_mul_start), 32'd1);
    req = '0;
    run_cycle();
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    for (int c = 4; c <= 10; c++) begin
      run_cycle();
      if (c == 4) check("div_rst_busy", 32'(s_mul_busy), 32'd0);
      check("div_rst_cdb", 32'(s_cdb_valid), 32'd0);
    end

`ifdef EXEC_SCHED_FLUSH_EN
    // Flush right after an add grant
    do_reset();
    set_req(0, 4'b0000, 3'd4);
    run_cycle();
    req = '0;
    flush = 1'b1;
    run_cycle();
    check("fl_cdb", 32'(s_cdb_valid), 32'd0);
    flush = 1'b0;
    for (int c = 2; c < 6; c++) begin
      run_cycle();
      if (c == 2) check("fl_busy", 32'(s_add_busy), 32'd0);
      check("fl_cdb_after", 32'(s_cdb_valid), 32'd0);
    end
`endif

    // Random traffic; granted entries drop req the next cycle
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      flush = FLUSH_ON && ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (e_grant[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          int r;
          r = $urandom_range(0, 9);
          set_req(i, (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15)), 3'($urandom_range(0, 7)));
        end else if (req[i] && unit_of(req_func[4*i +: 4]) < 0 && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b0;
        end
      end
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
